// File: rtl/four_to_one_mux_if.sv
// rtl/four_to_one_mux_if.sv - data, select and result bundle for four_to_one_mux
interface four_to_one_mux_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             s0;
  logic             s1;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_g;
  logic             mismatch;

  modport master (
    output a, b, c, d, s0, s1,
    input  out_b, out_d, out_g, mismatch
  );

  modport slave (
    input  a, b, c, d, s0, s1,
    output out_b, out_d, out_g, mismatch
  );
endinterface

// File: rtl/four_to_one_mux.sv
// rtl/four_to_one_mux.sv - 4:1 mux built three ways (behavioral, dataflow, gates), registered and cross-checked
module four_to_one_mux #(
  parameter int WIDTH = 1
) (
  input logic             clk,
  input logic             rst,
  four_to_one_mux_if.slave bus
);
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] sel_d;
  wire  [WIDTH-1:0] sel_g;
  wire              s0_n;
  wire              s1_n;

  always_comb begin
    sel_b = '0;
    case ({bus.s1, bus.s0})
      2'b00:   sel_b = bus.a;
      2'b01:   sel_b = bus.b;
      2'b10:   sel_b = bus.c;
      2'b11:   sel_b = bus.d;
      default: sel_b = '0;
    endcase
  end

  assign sel_d = ({WIDTH{~bus.s1 & ~bus.s0}} & bus.a)
               | ({WIDTH{~bus.s1 &  bus.s0}} & bus.b)
               | ({WIDTH{ bus.s1 & ~bus.s0}} & bus.c)
               | ({WIDTH{ bus.s1 &  bus.s0}} & bus.d);

  not u_inv_s0 (s0_n, bus.s0);
  not u_inv_s1 (s1_n, bus.s1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    wire t0, t1, t2, t3;
    and u_and0 (t0, s1_n,   s0_n,   bus.a[i]);
    and u_and1 (t1, s1_n,   bus.s0, bus.b[i]);
    and u_and2 (t2, bus.s1, s0_n,   bus.c[i]);
    and u_and3 (t3, bus.s1, bus.s0, bus.d[i]);
    or  u_or   (sel_g[i], t0, t1, t2, t3);
  end

  // Comparison uses the registered results, so a disagreement flags one edge after capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_b    <= '0;
      bus.out_d    <= '0;
      bus.out_g    <= '0;
      bus.mismatch <= 1'b0;
    end else begin
      bus.out_b    <= sel_b;
      bus.out_d    <= sel_d;
      bus.out_g    <= sel_g;
      bus.mismatch <= bus.mismatch | (bus.out_b != bus.out_d) | (bus.out_b != bus.out_g);
    end
  end
endmodule

// File: tb/tb_four_to_one_mux.sv
// tb/tb_four_to_one_mux.sv - directed self-checking bench for four_to_one_mux at WIDTH 1 and 8
module tb_four_to_one_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  four_to_one_mux_if #(.WIDTH(1)) bus1 ();
  four_to_one_mux_if #(.WIDTH(8)) bus8 ();

  four_to_one_mux #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  four_to_one_mux #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic s1, input logic s0, input logic a, input logic b,
                        input logic c, input logic d);
    bus1.s1 = s1; bus1.s0 = s0; bus1.a = a; bus1.b = b; bus1.c = c; bus1.d = d;
  endtask

  task automatic test_reset();
    drive1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus8.s1 = 1'b0; bus8.s0 = 1'b0;
    bus8.a = 8'hFF; bus8.b = 8'h00; bus8.c = 8'h00; bus8.d = 8'h00;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus1.out_b, bus1.out_d, bus1.out_g, bus1.mismatch} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_w1: got %b expected 0000", {bus1.out_b, bus1.out_d, bus1.out_g, bus1.mismatch});
    end
    checks++;
    if ({bus8.out_b, bus8.out_d, bus8.out_g, bus8.mismatch} !== 25'h0) begin
      errors++;
      $display("FAIL reset_w8: got %h %h %h %b expected 00 00 00 0",
               bus8.out_b, bus8.out_d, bus8.out_g, bus8.mismatch);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({bus1.out_b, bus1.out_d, bus1.out_g, bus1.mismatch} !== 4'b1110) begin
      errors++;
      $display("FAIL first_valid: got %b expected 1110", {bus1.out_b, bus1.out_d, bus1.out_g, bus1.mismatch});
    end
  endtask

  task automatic test_sweep();
    logic [5:0] v;
    logic [3:0] dat;
    logic       exp;
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      drive1(v[5], v[4], v[3], v[2], v[1], v[0]);
      dat = v[3:0];
      exp = dat[3 - int'(v[5:4])];
      tick();
      checks++;
      if ({bus1.out_b, bus1.out_d, bus1.out_g} !== {3{exp}}) begin
        errors++;
        $display("FAIL sweep_%0d: got b=%b d=%b g=%b expected %b", i, bus1.out_b, bus1.out_d, bus1.out_g, exp);
      end
      checks++;
      if (bus1.mismatch !== 1'b0) begin
        errors++;
        $display("FAIL sweep_mismatch_%0d: got %b expected 0", i, bus1.mismatch);
      end
    end
  endtask

  task automatic test_isolation();
    logic [3:0] exp_tab;
    logic [2:0] bcd;
    exp_tab = 4'b0001;
    for (int s = 0; s < 4; s++) begin
      drive1(s[1], s[0], 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if ({bus1.out_b, bus1.out_d, bus1.out_g} !== {3{exp_tab[s]}}) begin
        errors++;
        $display("FAIL isolation_sel%0d: got %b%b%b expected %b", s, bus1.out_b, bus1.out_d, bus1.out_g, exp_tab[s]);
      end
    end
    for (int k = 1; k < 8; k++) begin
      bcd = 3'(k);
      drive1(1'b0, 1'b0, 1'b1, bcd[2], bcd[1], bcd[0]);
      tick();
      checks++;
      if ({bus1.out_b, bus1.out_d, bus1.out_g} !== 3'b111) begin
        errors++;
        $display("FAIL isolation_toggle_%0d: got %b%b%b expected 111", k, bus1.out_b, bus1.out_d, bus1.out_g);
      end
    end
  endtask

  task automatic test_latency();
    drive1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    bus1.d = 1'b1;
    #1;
    checks++;
    if ({bus1.out_b, bus1.out_d, bus1.out_g} !== 3'b000) begin
      errors++;
      $display("FAIL latency_before: got %b%b%b expected 000", bus1.out_b, bus1.out_d, bus1.out_g);
    end
    tick();
    checks++;
    if ({bus1.out_b, bus1.out_d, bus1.out_g} !== 3'b111) begin
      errors++;
      $display("FAIL latency_after: got %b%b%b expected 111", bus1.out_b, bus1.out_d, bus1.out_g);
    end
  endtask

  task automatic test_reset_mid();
    drive1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    checks++;
    if ({bus1.out_b, bus1.out_d, bus1.out_g} !== 3'b111) begin
      errors++;
      $display("FAIL rst_glitch: got %b%b%b expected 111", bus1.out_b, bus1.out_d, bus1.out_g);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus1.out_b, bus1.out_d, bus1.out_g, bus1.mismatch} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid: got %b expected 0000", {bus1.out_b, bus1.out_d, bus1.out_g, bus1.mismatch});
    end
    tick();
    checks++;
    if ({bus1.out_b, bus1.out_d, bus1.out_g} !== 3'b111) begin
      errors++;
      $display("FAIL rst_restore: got %b%b%b expected 111", bus1.out_b, bus1.out_d, bus1.out_g);
    end
  endtask

  task automatic test_width8();
    logic [7:0] exp_tab [4];
    exp_tab[0] = 8'hA5; exp_tab[1] = 8'h3C; exp_tab[2] = 8'hF0; exp_tab[3] = 8'h0F;
    bus8.a = 8'hA5; bus8.b = 8'h3C; bus8.c = 8'hF0; bus8.d = 8'h0F;
    for (int s = 0; s < 4; s++) begin
      bus8.s1 = s[1];
      bus8.s0 = s[0];
      tick();
      checks++;
      if (bus8.out_b !== exp_tab[s] || bus8.out_d !== exp_tab[s] || bus8.out_g !== exp_tab[s]) begin
        errors++;
        $display("FAIL width8_sel%0d: got b=%h d=%h g=%h expected %h", s, bus8.out_b, bus8.out_d, bus8.out_g, exp_tab[s]);
      end
    end
    tick();
    checks++;
    if (bus8.mismatch !== 1'b0) begin
      errors++;
      $display("FAIL width8_mismatch: got %b expected 0", bus8.mismatch);
    end
  endtask

  task automatic test_sticky();
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (bus1.mismatch !== 1'b0) begin
      errors++;
      $display("FAIL sticky_pre: got %b expected 0", bus1.mismatch);
    end
    force dut1.sel_d = 1'b1;
    tick();
    release dut1.sel_d;
    checks++;
    if (bus1.out_d !== 1'b1 || bus1.out_b !== 1'b0) begin
      errors++;
      $display("FAIL sticky_override: got b=%b d=%b expected b=0 d=1", bus1.out_b, bus1.out_d);
    end
    tick();
    checks++;
    if (bus1.mismatch !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set: got %b expected 1", bus1.mismatch);
    end
    tick();
    tick();
    tick();
    checks++;
    if (bus1.mismatch !== 1'b1 || bus1.out_d !== 1'b0) begin
      errors++;
      $display("FAIL sticky_hold: got mismatch=%b out_d=%b expected 1 0", bus1.mismatch, bus1.out_d);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus1.mismatch !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear: got %b expected 0", bus1.mismatch);
    end
    tick();
    checks++;
    if (bus1.mismatch !== 1'b0) begin
      errors++;
      $display("FAIL sticky_after_clear: got %b expected 0", bus1.mismatch);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_isolation();
    test_latency();
    test_reset_mid();
    test_width8();
    test_sticky();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/four_to_one_mux.md
FOUR_TO_ONE_MUX -- requirements
Module: four_to_one_mux

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of each data input and each data output.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock; all registers sample on it.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 a  input  WIDTH  data input 0, selected when {s1,s0}=00.
REQ-006 b  input  WIDTH  data input 1, selected when {s1,s0}=01.
REQ-007 c  input  WIDTH  data input 2, selected when {s1,s0}=10.
REQ-008 d  input  WIDTH  data input 3, selected when {s1,s0}=11.
REQ-009 s0  input  1  select LSB.
REQ-010 s1  input  1  select MSB.
REQ-011 out_b  output  WIDTH  registered result of the behavioral select path.
REQ-012 out_d  output  WIDTH  registered result of the dataflow select path.
REQ-013 out_g  output  WIDTH  registered result of the gate-level select path.
REQ-014 mismatch  output  1  sticky flag; set when the three paths disagree.

Function
REQ-015 Select mapping for all paths: {s1,s0} 00->a, 01->b, 10->c, 11->d, applied bitwise across WIDTH.
REQ-016 Behavioral path: case/if decode of {s1,s0} in a combinational block.
- Any non-0/1 select value drives all-zero.
REQ-017 Dataflow path: continuous-assignment sum-of-products.
- (~s1&~s0&a) | (~s1&s0&b) | (s1&~s0&c) | (s1&s0&d), with select bits replicated to WIDTH.
REQ-018 Gate-level path: built only from NOT/AND/OR primitives.
- Two inverters for the selects.
- Four 3-input ANDs and one 4-input OR per bit, generated per bit of WIDTH.
REQ-019 Each path result is registered into its output on every rising clk edge when rst=0.
- Latency exactly 1 cycle from input change to output.
- No enable; outputs update every cycle.
REQ-020 Compare logic: registers the three combinational results, then compares them.
- mismatch is set on the next edge when any result differs from the others (not all three equal).
REQ-021 mismatch is sticky: once 1, it remains 1 until rst.
REQ-022 With 0/1-valued inputs, out_b, out_d and out_g SHALL be identical every cycle, and mismatch SHALL stay 0.
REQ-023 Inputs not selected have no effect on any output.
REQ-024 No combinational path from any input to any output.

Reset
REQ-025 While rst=1 at a rising edge: out_b, out_d, out_g <= 0 and mismatch <= 0.
REQ-026 Reset takes priority over data capture; inputs sampled at that edge are discarded.
REQ-027 The first valid output appears at the first edge with rst=0.
REQ-028 Reset asserted mid-operation clears all outputs at the next edge, regardless of the current inputs or mismatch state.
REQ-029 No asynchronous behaviour; rst changes between edges have no effect.

Verification
REQ-030 Exhaustive sweep, WIDTH=1: drive {s1,s0,a,b,c,d}=0..63, one value per cycle.
- Each output equals the selected input one cycle later.
- mismatch stays 0.
REQ-031 Isolation: a=1, b=0, c=0, d=0.
- Cycle through {s1,s0}=00,01,10,11 -> outputs 1,0,0,0.
- Toggling b, c or d while {s1,s0}=00 leaves outputs at 1.
REQ-032 Latency: {s1,s0}=11, d toggles 0->1 at edge N.
- All three outputs are 0 through edge N and 1 after edge N+1.
REQ-033 Reset mid-run: outputs at 1, rst=1 for one edge -> outputs 0 and mismatch 0.
- Next edge with rst=0 restores the selected value.
REQ-034 WIDTH=8: a=8'hA5, b=8'h3C, c=8'hF0, d=8'h0F.
- Selects 00/01/10/11 -> outputs A5/3C/F0/0F after 1 cycle.
- All three outputs are equal.
REQ-035 Sticky flag: force a single-cycle internal disagreement (bench override of one path) -> mismatch=1.
- mismatch stays 1 after the override is released and only clears on rst.
